// File: rtl/traffic_pkg.sv
// Shared lamp, fault-code and monitor-state types plus the {r,o,g} lamp decoder.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED     = 2'd0,
    ORANGE  = 2'd1,
    GREEN   = 2'd2,
    ILLEGAL = 2'd3
  } lamp_state_t;

  typedef enum logic [2:0] {
    FC_NONE         = 3'd0,
    FC_ILLEGAL      = 3'd1,
    FC_CONFLICT     = 3'd2,
    FC_SKIP_ORANGE  = 3'd3,
    FC_SHORT_GREEN  = 3'd4,
    FC_SHORT_ORANGE = 3'd5,
    FC_STALL        = 3'd6
  } fault_code_t;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    MONITOR = 2'd1,
    FAULT   = 2'd2
  } mon_state_t;

  function automatic lamp_state_t lamp_decode(input logic r, input logic o, input logic g);
    lamp_state_t s;
    case ({r, o, g})
      3'b100:  s = RED;
      3'b010:  s = ORANGE;
      3'b001:  s = GREEN;
      default: s = ILLEGAL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tlm_dir_checker.sv
// One direction's lamp tracker: previous state, saturating duration counter and per-edge rule flags.
// Flags are combinational on the current inputs; tracker state updates every cycle, no backpressure.
module tlm_dir_checker
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_ORANGE = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       r_i,
  input  logic       o_i,
  input  logic       g_i,
  output logic [1:0] state_o,
  output logic       changed_o,
  output logic       illegal_o,
  output logic       seq_err_o,
  output logic       short_green_o,
  output logic       short_orange_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_G_CNT = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_O_CNT = CNT_W'(MIN_ORANGE);

  lamp_state_t      cur_w;
  lamp_state_t      prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cur_w = lamp_decode(r_i, o_i, g_i);

  always_comb begin
    prev_d = cur_w;
    cnt_d  = cnt_q;
    if (cur_w != prev_q) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clr_i) begin
      prev_q <= RED;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  // cnt_q is the number of cycles the previous state was held when a transition is seen.
  assign state_o        = cur_w;
  assign changed_o      = (cur_w != prev_q);
  assign illegal_o      = (cur_w == ILLEGAL);
  assign seq_err_o      = ((prev_q == GREEN)  && (cur_w == RED))    ||
                          ((prev_q == ORANGE) && (cur_w == GREEN))  ||
                          ((prev_q == RED)    && (cur_w == ORANGE));
  assign short_green_o  = (prev_q == GREEN)  && (cur_w == ORANGE) && (cnt_q < MIN_G_CNT);
  assign short_orange_o = (prev_q == ORANGE) && (cur_w == RED)    && (cnt_q < MIN_O_CNT);

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Lamp safety stage: re-registers the 12 lamps, latches the first rule violation and flashes red until cleared.
// 1-cycle lamp latency, no backpressure; define TLM_WATCHDOG_EN to add the stall watchdog (code 6).
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN      = 4,
  parameter int MIN_ORANGE     = 2,
  parameter int STARTUP_CYCLES = 8,
  parameter int FLASH_HALF     = 4,
  parameter int CNT_W          = 8,
  parameter int WDOG_CYCLES    = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fault_clr,
  input  logic [3:0] red_in,
  input  logic [3:0] orange_in,
  input  logic [3:0] green_in,
  output logic [3:0] red_out,
  output logic [3:0] orange_out,
  output logic [3:0] green_out,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int SU_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int FL_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [SU_W-1:0] SU_LAST = SU_W'(STARTUP_CYCLES - 1);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLASH_HALF - 1);

  logic [3:0][1:0] st_w;
  logic [3:0]      chg_w, ill_w, seq_w, sg_w, so_w, nonred_w;
  logic            all_red_in, clr_fault, conflict, stall_hit;
  fault_code_t     fc_w;

  mon_state_t      state_q;
  logic [SU_W-1:0] su_cnt_q;
  logic [FL_W-1:0] fl_cnt_q;
  logic            flash_on_q;
  logic [3:0]      red_q, orange_q, green_q;
  logic            fault_q;
  fault_code_t     code_q;

  assign all_red_in = (red_in == 4'hF) && (orange_in == 4'h0) && (green_in == 4'h0);
  assign clr_fault  = (state_q == FAULT) && fault_clr && all_red_in;

  for (genvar i = 0; i < 4; i++) begin : g_dir
    tlm_dir_checker #(
      .MIN_GREEN  (MIN_GREEN),
      .MIN_ORANGE (MIN_ORANGE),
      .CNT_W      (CNT_W)
    ) u_chk (
      .clk            (clk),
      .rst            (rst),
      .clr_i          (clr_fault),
      .r_i            (red_in[i]),
      .o_i            (orange_in[i]),
      .g_i            (green_in[i]),
      .state_o        (st_w[i]),
      .changed_o      (chg_w[i]),
      .illegal_o      (ill_w[i]),
      .seq_err_o      (seq_w[i]),
      .short_green_o  (sg_w[i]),
      .short_orange_o (so_w[i])
    );
    assign nonred_w[i] = (lamp_state_t'(st_w[i]) == ORANGE) || (lamp_state_t'(st_w[i]) == GREEN);
  end

  // More than one bit set in nonred_w.
  assign conflict = (nonred_w & (nonred_w - 4'd1)) != 4'd0;

`ifdef TLM_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] stall_q, stall_d;

  assign stall_d   = (|chg_w) ? '0 : stall_q + 1'b1;
  assign stall_hit = (state_q == MONITOR) && (stall_d >= WD_W'(WDOG_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst || (state_q != MONITOR)) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^{WDOG_CYCLES, chg_w};
  assign stall_hit   = 1'b0;
`endif

  always_comb begin
    fc_w = FC_NONE;
    if (|ill_w)          fc_w = FC_ILLEGAL;
    else if (conflict)   fc_w = FC_CONFLICT;
    else if (|seq_w)     fc_w = FC_SKIP_ORANGE;
    else if (|sg_w)      fc_w = FC_SHORT_GREEN;
    else if (|so_w)      fc_w = FC_SHORT_ORANGE;
    else if (stall_hit)  fc_w = FC_STALL;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= STARTUP;
      su_cnt_q   <= '0;
      fl_cnt_q   <= '0;
      flash_on_q <= 1'b1;
      red_q      <= 4'hF;
      orange_q   <= 4'h0;
      green_q    <= 4'h0;
      fault_q    <= 1'b0;
      code_q     <= FC_NONE;
    end else begin
      case (state_q)
        STARTUP: begin
          red_q    <= 4'hF;
          orange_q <= 4'h0;
          green_q  <= 4'h0;
          if (su_cnt_q == SU_LAST) begin
            state_q  <= MONITOR;
            su_cnt_q <= '0;
          end else begin
            su_cnt_q <= su_cnt_q + 1'b1;
          end
        end
        MONITOR: begin
          if (fc_w != FC_NONE) begin
            // The offending pattern is replaced by all-red on the detection edge.
            state_q    <= FAULT;
            fault_q    <= 1'b1;
            code_q     <= fc_w;
            red_q      <= 4'hF;
            orange_q   <= 4'h0;
            green_q    <= 4'h0;
            fl_cnt_q   <= '0;
            flash_on_q <= 1'b1;
          end else begin
            red_q    <= red_in;
            orange_q <= orange_in;
            green_q  <= green_in;
          end
        end
        FAULT: begin
          orange_q <= 4'h0;
          green_q  <= 4'h0;
          if (clr_fault) begin
            state_q  <= STARTUP;
            fault_q  <= 1'b0;
            code_q   <= FC_NONE;
            su_cnt_q <= '0;
            red_q    <= 4'hF;
          end else if (fl_cnt_q == FL_LAST) begin
            fl_cnt_q   <= '0;
            flash_on_q <= ~flash_on_q;
            red_q      <= {4{~flash_on_q}};
          end else begin
            fl_cnt_q <= fl_cnt_q + 1'b1;
            red_q    <= {4{flash_on_q}};
          end
        end
        default: begin
          state_q <= STARTUP;
          red_q   <= 4'hF;
        end
      endcase
    end
  end

  assign red_out    = red_q;
  assign orange_out = orange_q;
  assign green_out  = green_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: vector table, directed corner sequences, random walk vs reference model.
module tb_traffic_conflict_monitor;

  localparam int MIN_GREEN      = 4;
  localparam int MIN_ORANGE     = 2;
  localparam int STARTUP_CYCLES = 8;
  localparam int FLASH_HALF     = 4;
  localparam int WDOG_CYCLES    = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fault_clr = 1'b0;
  logic [3:0] red_in = 4'hF, orange_in = 4'h0, green_in = 4'h0;
  logic [3:0] red_out, orange_out, green_out;
  logic       fault;
  logic [2:0] fault_code;
  logic [15:0] dut_o;

  traffic_conflict_monitor #(
    .MIN_GREEN      (MIN_GREEN),
    .MIN_ORANGE     (MIN_ORANGE),
    .STARTUP_CYCLES (STARTUP_CYCLES),
    .FLASH_HALF     (FLASH_HALF),
    .CNT_W          (8),
    .WDOG_CYCLES    (WDOG_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fault_clr  (fault_clr),
    .red_in     (red_in),
    .orange_in  (orange_in),
    .green_in   (green_in),
    .red_out    (red_out),
    .orange_out (orange_out),
    .green_out  (green_out),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  assign dut_o = {red_out, orange_out, green_out, fault, fault_code};

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got r=%b o=%b g=%b fault=%b code=%0d, expected r=%b o=%b g=%b fault=%b code=%0d",
                  nm, act[15:12], act[11:8], act[7:4], act[3], act[2:0],
                  exp[15:12], exp[11:8], exp[7:4], exp[3], exp[2:0]);
  endtask

  // Reference model: lamp states as ints (0 red, 1 orange, 2 green, 3 illegal), modes 0 startup / 1 monitor / 2 fault.
  int          m_mode, m_su, m_fage, m_stall, m_code;
  int          m_prev[4];
  int          m_cnt[4];
  logic [15:0] m_exp;

  function automatic int dec(input logic [2:0] p);
    if (p == 3'b100) return 0;
    if (p == 3'b010) return 1;
    if (p == 3'b001) return 2;
    return 3;
  endfunction

  task automatic model_step(input logic rs, input logic cl, input logic [3:0] r, input logic [3:0] o,
                            input logic [3:0] g);
    int cur[4];
    int code, nonred, p, c;
    bit ill, seq, sg, so, all_red, clr_now;
    if (!rs) begin
      m_mode = 0; m_su = 0; m_fage = 0; m_stall = 0; m_code = 0;
      for (int i = 0; i < 4; i++) begin m_prev[i] = 0; m_cnt[i] = 0; end
      m_exp = {4'hF, 12'h000};
      return;
    end
    code = 0; nonred = 0; ill = 0; seq = 0; sg = 0; so = 0; all_red = 1; clr_now = 0;
    for (int i = 0; i < 4; i++) begin
      cur[i] = dec({r[i], o[i], g[i]});
      p = m_prev[i]; c = cur[i];
      if (c == 3) ill = 1;
      if (c == 1 || c == 2) nonred++;
      if (c != 0) all_red = 0;
      if ((p == 2 && c == 0) || (p == 1 && c == 2) || (p == 0 && c == 1)) seq = 1;
      if (p == 2 && c == 1 && m_cnt[i] < MIN_GREEN) sg = 1;
      if (p == 1 && c == 0 && m_cnt[i] < MIN_ORANGE) so = 1;
    end
    case (m_mode)
      0: begin
        m_stall = 0;
        m_su++;
        m_exp = {4'hF, 12'h000};
        if (m_su == STARTUP_CYCLES) begin m_mode = 1; m_su = 0; end
      end
      1: begin
        if (ill) code = 1;
        else if (nonred > 1) code = 2;
        else if (seq) code = 3;
        else if (sg) code = 4;
        else if (so) code = 5;
`ifdef TLM_WATCHDOG_EN
        begin
          bit chg;
          chg = 0;
          for (int i = 0; i < 4; i++) if (cur[i] != m_prev[i]) chg = 1;
          m_stall = chg ? 0 : m_stall + 1;
          if (code == 0 && m_stall >= WDOG_CYCLES) code = 6;
        end
`endif
        if (code != 0) begin
          m_mode = 2; m_fage = 0; m_code = code;
          m_exp = {4'hF, 8'h00, 1'b1, 3'(code)};
        end else begin
          m_exp = {r, o, g, 4'h0};
        end
      end
      default: begin
        m_stall = 0;
        if (cl && all_red) begin
          m_mode = 0; m_su = 0; m_code = 0; clr_now = 1;
          m_exp = {4'hF, 12'h000};
        end else begin
          m_fage++;
          m_exp = {(((m_fage / FLASH_HALF) % 2) == 0) ? 4'hF : 4'h0, 8'h00, 1'b1, 3'(m_code)};
        end
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      if (clr_now) begin m_prev[i] = 0; m_cnt[i] = 0; end
      else if (cur[i] == m_prev[i]) m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
      else begin m_prev[i] = cur[i]; m_cnt[i] = 1; end
    end
  endtask

  task automatic cycle(input logic rs, input logic cl, input logic [3:0] r, input logic [3:0] o,
                       input logic [3:0] g, input string nm);
    rst = rs; fault_clr = cl; red_in = r; orange_in = o; green_in = g;
    model_step(rs, cl, r, o, g);
    @(posedge clk);
    #1;
    chk(nm, dut_o, m_exp);
  endtask

  task automatic hold(input int n, input logic [3:0] r, input logic [3:0] o, input logic [3:0] g,
                      input string nm);
    repeat (n) cycle(1'b1, 1'b0, r, o, g, nm);
  endtask

  task automatic boot();
    cycle(1'b0, 1'b0, 4'hF, 4'h0, 4'h0, "boot_rst");
    hold(STARTUP_CYCLES, 4'hF, 4'h0, 4'h0, "boot");
  endtask

  typedef struct packed {
    logic        rs;
    logic        cl;
    logic [3:0]  r;
    logic [3:0]  o;
    logic [3:0]  g;
    logic [15:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic cl, input logic [3:0] r, input logic [3:0] o,
                              input logic [3:0] g, input logic [3:0] er, input logic [3:0] eo,
                              input logic [3:0] eg, input logic ef, input logic [2:0] ec);
    vec_t v;
    v.rs = rs; v.cl = cl; v.r = r; v.o = o; v.g = g;
    v.exp = {er, eo, eg, ef, ec};
    return v;
  endfunction

  function automatic logic [2:0] nxt(input logic [2:0] p);
    case (p)
      3'b100:  return 3'b001;
      3'b001:  return 3'b010;
      3'b010:  return 3'b100;
      default: return 3'b100;
    endcase
  endfunction

  vec_t tbl[$];
  logic [2:0] pat[4];

  initial begin
    // Reset, startup, legal dir1 cycle, conflict, flash, ignored/accepted clear, short green.
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(1, 0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 0, 4'b1110, 4'h0, 4'b0001, 4'b1110, 4'h0, 4'b0001, 0, 0));
    for (int k = 0; k < 2; k++) tbl.push_back(mk(1, 0, 4'b1110, 4'b0001, 4'h0, 4'b1110, 4'b0001, 4'h0, 0, 0));
    tbl.push_back(mk(1, 0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b1010, 4'h0, 4'b0101, 4'hF, 4'h0, 4'h0, 1, 2));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(1, 0, 4'hF, 4'h0, 4'h0, (((k / 4) % 2) == 0) ? 4'hF : 4'h0, 4'h0, 4'h0, 1, 2));
    tbl.push_back(mk(1, 1, 4'b1110, 4'h0, 4'b0001, 4'hF, 4'h0, 4'h0, 1, 2));
    tbl.push_back(mk(1, 1, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(1, 0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 4'b1101, 4'h0, 4'b0010, 4'b1101, 4'h0, 4'b0010, 0, 0));
    tbl.push_back(mk(1, 0, 4'b1101, 4'b0010, 4'h0, 4'hF, 4'h0, 4'h0, 1, 4));
    tbl.push_back(mk(1, 0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1, 4));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rs; fault_clr = tbl[i].cl;
      red_in = tbl[i].r; orange_in = tbl[i].o; green_in = tbl[i].g;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d", i), dut_o, tbl[i].exp);
    end

    boot();
    hold(4, 4'b1101, 4'h0, 4'b0010, "so_g");
    hold(1, 4'b1101, 4'b0010, 4'h0, "so_o");
    hold(1, 4'hF, 4'h0, 4'h0, "so_r");
    chk("short_orange", dut_o, {4'hF, 8'h00, 1'b1, 3'd5});

    boot();
    hold(2, 4'b1101, 4'h0, 4'b0010, "sk_g");
    hold(1, 4'hF, 4'h0, 4'h0, "sk_r");
    chk("skip_orange", dut_o, {4'hF, 8'h00, 1'b1, 3'd3});

    boot();
    hold(1, 4'b1100, 4'h0, 4'b1011, "ill");
    chk("illegal_prio", dut_o, {4'hF, 8'h00, 1'b1, 3'd1});
    hold(4, 4'hF, 4'h0, 4'h0, "ill_flash");
    chk("flash_off", dut_o, {4'h0, 8'h00, 1'b1, 3'd1});
    cycle(1'b0, 1'b0, 4'hF, 4'h0, 4'h0, "rst_mid");
    chk("rst_mid_fault", dut_o, {4'hF, 12'h000});

    boot();
    hold(WDOG_CYCLES, 4'hF, 4'h0, 4'h0, "wdog_hold");
`ifdef TLM_WATCHDOG_EN
    chk("wdog_stall", dut_o, {4'hF, 8'h00, 1'b1, 3'd6});
`else
    chk("no_wdog", dut_o, {4'hF, 12'h000});
`endif

    for (int i = 0; i < 4; i++) pat[i] = 3'b100;
    cycle(1'b0, 1'b0, 4'hF, 4'h0, 4'h0, "rand_rst");
    for (int n = 0; n < 3000; n++) begin
      int k, d;
      logic [3:0] r, o, g;
      k = $urandom_range(0, 99);
      d = $urandom_range(0, 3);
      if (k < 3) pat[d] = 3'($urandom_range(0, 7));
      else if (k < 13) for (int i = 0; i < 4; i++) pat[i] = 3'b100;
      else if (k < 43) pat[d] = nxt(pat[d]);
      else if (k < 50) begin
        case ($urandom_range(0, 2))
          0:       pat[d] = 3'b100;
          1:       pat[d] = 3'b010;
          default: pat[d] = 3'b001;
        endcase
      end
      for (int i = 0; i < 4; i++) begin
        r[i] = pat[i][2]; o[i] = pat[i][1]; g[i] = pat[i][0];
      end
      cycle(($urandom_range(0, 499) != 0), ($urandom_range(0, 7) == 0), r, o, g, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
- Safety stage directly downstream of the 4-direction traffic_light controller.
- Consumes the controller's 12 lamp outputs (Red/Orange/Green × 4 directions) and re-drives them to the lamp drivers through a register.
- Checks lamp legality, cross-direction conflict, sequencing and minimum phase durations.
- On any violation it latches a fault, reports a code and forces all directions to flashing red until cleared.

Parameters:
- MIN_GREEN, 4, minimum cycles a direction must hold green before going orange.
- MIN_ORANGE, 2, minimum cycles a direction must hold orange before going red.
- STARTUP_CYCLES, 8, cycles of forced all-red after reset before monitoring starts.
- FLASH_HALF, 4, cycles per half-period of fault-mode red flashing.
- CNT_W, 8, width of per-direction duration counters (saturating).
- WDOG_CYCLES, 200, stall limit; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-low (asserted when 0)
- fault_clr  in  1  single-cycle request to leave FAULT
- red_in  in  4  controller red lamps, bit i = direction i+1
- orange_in  in  4  controller orange lamps
- green_in  in  4  controller green lamps
- red_out  out  4  registered red lamp drive
- orange_out  out  4  registered orange lamp drive
- green_out  out  4  registered green lamp drive
- fault  out  1  latched fault flag
- fault_code  out  3  latched code of the first fault

Behaviour:
- Reset (rst==0 at a clk edge):
  - red_out=4'b1111, orange_out=0, green_out=0.
  - fault=0, fault_code=0.
  - State=STARTUP, startup counter=0, flash phase=on.
  - Direction trackers set to RED with count 0.
- Per-direction decode of {r,o,g}: 100=RED, 010=ORANGE, 001=GREEN, anything else=ILLEGAL.
- Each direction keeps its previous decoded state and a saturating CNT_W counter.
  - The counter is 1 on the first cycle of a new state and increments while the state is held.
- STARTUP:
  - Outputs are forced all-red and no checks are made.
  - After STARTUP_CYCLES cycles the block moves to MONITOR.
  - fault_clr is ignored.
- MONITOR: the output register loads the inputs, giving 1-cycle latency. Checks are made on the current inputs in the same cycle. Fault codes:
  - 1 ILLEGAL: any direction decodes ILLEGAL.
  - 2 CONFLICT: more than one direction is non-RED (ORANGE or GREEN).
  - 3 SKIP_ORANGE: a direction goes GREEN→RED.
  - 4 SHORT_GREEN: a GREEN→ORANGE transition with counter < MIN_GREEN.
  - 5 SHORT_ORANGE: an ORANGE→RED transition with counter < MIN_ORANGE.
  - RED→GREEN is legal. ORANGE→GREEN and RED→ORANGE raise code 3 (sequence error).
- Fault handling:
  - If several faults occur in the same cycle, the lowest code wins.
  - On the detection edge: fault=1, fault_code is loaded, state=FAULT.
  - On that same edge the output register loads all-red, not the offending pattern, so an illegal pattern never reaches the outputs.
- FAULT:
  - orange_out=0, green_out=0.
  - red_out toggles between 1111 and 0000 every FLASH_HALF cycles, starting at 1111.
  - fault and fault_code hold.
  - Input trackers keep updating.
- Leaving FAULT: fault_clr=1 while all four inputs decode RED → STARTUP, fault=0, fault_code=0, counters reset. fault_clr at any other time is ignored.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset mid-FAULT or mid-MONITOR behaves exactly like power-up reset.

Optional Feature:
- Macro TLM_WATCHDOG_EN.
- When defined:
  - In MONITOR, a stall counter increments each cycle that no direction changes state.
  - Any change resets the stall counter.
  - Reaching WDOG_CYCLES raises code 6 STALL, which has the lowest priority.
- When undefined: no stall counter, and code 6 is never produced.

Decomposition:
- traffic_pkg holds:
  - lamp_state_t enum (RED, ORANGE, GREEN, ILLEGAL)
  - fault_code_t 3-bit enum (NONE=0 … STALL=6)
  - mon_state_t enum (STARTUP, MONITOR, FAULT)
  - decode function {r,o,g}→lamp_state_t
- One sub-module, tlm_dir_checker, instantiated 4×:
  - Holds the previous state and duration counter for one direction.
  - Outputs decoded state, illegal, seq_err, short_green and short_orange.
- The top level does the conflict OR-reduction, priority encoding, FSM, flash timer and output register.

Test Plan:
- Reset then 8 cycles all-red input → outputs 1111/0/0 throughout. After cycle 9, a legal sequence (dir1 G×4, O×2, R) passes through with 1-cycle latency and fault stays 0.
- Dir1 green and dir3 green in the same cycle during MONITOR → next edge fault=1, fault_code=2. Outputs never show two greens. red_out flashes 1111/0000 every 4 cycles.
- Dir2 G for 3 cycles then O → fault_code=4. Separately, dir2 O for 1 cycle then R → fault_code=5. Separately, dir2 G→R → fault_code=3.
- Dir4 inputs r=1,g=1 together with dir1+dir2 green → fault_code=1 (priority over 2).
- In FAULT: fault_clr with dir1 green → ignored. fault_clr with all-red → fault=0, code 0, 8 cycles forced red, then MONITOR.
- With TLM_WATCHDOG_EN and WDOG_CYCLES=200: hold inputs constant for 200 MONITOR cycles → fault_code=6. Without the macro, the same stimulus never faults. Also: rst=0 mid-FAULT → all outputs return to their reset values on the next edge.
